// File: rtl/imm_encoder.sv
// Streaming RISC-V immediate packer with registered output and one-entry skid buffer.
// Optional macro IMM_ROUNDTRIP_CHECK_EN adds a sticky decode-back self check (chk_err).
module imm_encoder #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       imm_src,
    input  logic [W-1:0]     imm,
    input  logic [31:0]      base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_range_err,
`ifdef IMM_ROUNDTRIP_CHECK_EN
    output logic             chk_err,
`endif
    output logic [CNT_W-1:0] err_count
);

    // state | meaning
    // EMPTY | main and skid empty
    // ONE   | main holds a word, skid empty
    // FULL  | main and skid both hold words, input stalled
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t      state;
    logic [31:0] pack;
    logic        range_err;
    logic [31:0] skid_instr;
    logic        skid_err;
    logic        accept, pop, load_in_main, load_skid, load_skid_main;

    always_comb begin
        pack = base;
        case (imm_src)
            2'b00: pack[31:20] = imm[11:0];
            2'b01: begin
                pack[31:25] = imm[11:5];
                pack[11:7]  = imm[4:0];
            end
            2'b10: begin
                pack[31]    = imm[12];
                pack[30:25] = imm[10:5];
                pack[11:8]  = imm[4:1];
                pack[7]     = imm[11];
            end
            default: begin
                pack[31]    = imm[20];
                pack[30:21] = imm[10:1];
                pack[20]    = imm[11];
                pack[19:12] = imm[19:12];
            end
        endcase
    end

    // Upper bits must be a pure sign extension; branch/jump offsets must be even.
    always_comb begin
        case (imm_src)
            2'b00, 2'b01: range_err = !((&imm[W-1:11]) || !(|imm[W-1:11]));
            2'b10:        range_err = !((&imm[W-1:12]) || !(|imm[W-1:12])) || imm[0];
            default:      range_err = !((&imm[W-1:20]) || !(|imm[W-1:20])) || imm[0];
        endcase
    end

    assign accept         = in_valid && in_ready;
    assign pop            = out_valid && out_ready;
    assign load_in_main   = accept && ((state == EMPTY) || pop);
    assign load_skid      = accept && (state == ONE) && !pop;
    assign load_skid_main = (state == FULL) && pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            out_valid     <= 1'b0;
            in_ready      <= 1'b1;
            out_instr     <= '0;
            out_range_err <= 1'b0;
            skid_instr    <= '0;
            skid_err      <= 1'b0;
            err_count     <= '0;
        end else begin
            if (load_in_main) begin
                out_instr     <= pack;
                out_range_err <= range_err;
            end else if (load_skid_main) begin
                out_instr     <= skid_instr;
                out_range_err <= skid_err;
            end
            if (load_skid) begin
                skid_instr <= pack;
                skid_err   <= range_err;
            end
            case (state)
                EMPTY: if (accept) begin
                    state     <= ONE;
                    out_valid <= 1'b1;
                end
                ONE: if (load_skid) begin
                    state    <= FULL;
                    in_ready <= 1'b0;
                end else if (pop && !accept) begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
                FULL: if (pop) begin
                    state    <= ONE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
            if (accept && range_err && !(&err_count))
                err_count <= err_count + 1'b1;
        end
    end

`ifdef IMM_ROUNDTRIP_CHECK_EN
    logic pack_mis, skid_mis;

    function automatic logic [31:0] unpack(input logic [31:0] i, input logic [1:0] s);
        case (s)
            2'b00:   return {{20{i[31]}}, i[31:20]};
            2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
            2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    // Mismatch is judged at pack time and carried with the word until it reaches main.
    assign pack_mis = !range_err && (unpack(pack, imm_src) != imm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_mis <= 1'b0;
            chk_err  <= 1'b0;
        end else begin
            if (load_skid)
                skid_mis <= pack_mis;
            if ((load_in_main && pack_mis) || (load_skid_main && skid_mis))
                chk_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: randomized words against a bit-mapping reference model.
module tb_imm_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  imm_src = '0;
    logic [31:0] imm = '0;
    logic [31:0] base = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_range_err;
    logic [15:0] err_count;
`ifdef IMM_ROUNDTRIP_CHECK_EN
    logic        chk_err;
`endif

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    logic [32:0] q[$];
    bit rand_phase = 1'b0;

    imm_encoder #(.W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .imm_src(imm_src), .imm(imm), .base(base), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_range_err(out_range_err),
`ifdef IMM_ROUNDTRIP_CHECK_EN
        .chk_err(chk_err),
`endif
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Which immediate bit lands on instruction bit k, or -1 if the bit comes from base.
    function automatic int src_map(input logic [1:0] s, input int k);
        case (s)
            2'd0: return (k >= 20) ? k - 20 : -1;
            2'd1: begin
                if (k >= 25) return k - 20;
                if (k >= 7 && k <= 11) return k - 7;
                return -1;
            end
            2'd2: begin
                if (k == 31) return 12;
                if (k >= 25) return k - 20;
                if (k >= 8 && k <= 11) return k - 7;
                if (k == 7) return 11;
                return -1;
            end
            default: begin
                if (k == 31) return 20;
                if (k >= 21) return k - 20;
                if (k == 20) return 11;
                if (k >= 12) return k;
                return -1;
            end
        endcase
    endfunction

    function automatic logic [32:0] model(input logic [1:0] s, input logic [31:0] im,
                                          input logic [31:0] b);
        logic [31:0] r;
        longint v, lim;
        int n, idx;
        bit e;
        for (int k = 0; k < 32; k++) begin
            idx = src_map(s, k);
            r[k] = (idx < 0) ? b[k] : im[idx];
        end
        n = (s < 2) ? 12 : (s == 2) ? 13 : 21;
        lim = longint'(1) << (n - 1);
        v = longint'($signed(im));
        e = (v < -lim) || (v > lim - 1) || ((s >= 2) && im[0]);
        return {e, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%08h with no word pending", out_instr);
            end else begin
                logic [32:0] e;
                e = q.pop_front();
                check("out_instr", out_instr, e[31:0]);
                check("out_range_err", {31'd0, out_range_err}, {31'd0, e[32]});
            end
        end
    end

    task automatic send(input logic [1:0] s, input logic [31:0] im, input logic [31:0] b);
        int n = 0;
        bit done = 1'b0;
        logic [32:0] e;
        imm_src = s; imm = im; base = b; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e = model(s, im, b);
                q.push_back(e);
                if (e[32] && model_cnt < 65535) model_cnt++;
                done = 1'b1;
            end else if (++n > 2000) begin
                check("accept_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_remaining", q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 4095)) - 32'd2048;
            2: return (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
            default: begin
                logic [31:0] edges [8];
                edges = '{32'h7FF, 32'hFFFFF800, 32'h800, 32'hFFF, 32'hFFFFF000,
                          32'hFFFFE, 32'hFFF00000, 32'h100000};
                return edges[$urandom_range(0, 7)];
            end
        endcase
    endfunction

    initial begin
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_instr", out_instr, 32'd0);
        check("reset_err_count", {16'd0, err_count}, 32'd0);

        send(2'b00, 32'hFFFFFFFF, 32'h00000093);
        check("i_latency_valid", {31'd0, out_valid}, 32'd1);
        check("i_latency_instr", out_instr, 32'hFFF00093);
        send(2'b01, 32'd8, 32'h00002023);
        send(2'b10, 32'hFFFFFFFC, 32'h00000063);
        send(2'b11, 32'd8, 32'h0000006F);
        drain();
        send(2'b00, 32'd2048, 32'h00000093);
        check("err_count_1", {16'd0, err_count}, 32'd1);
        send(2'b10, 32'd3, 32'h00000063);
        check("err_count_2", {16'd0, err_count}, 32'd2);
        drain();

        rand_phase = 1'b1;
        fork
            begin
                for (int i = 0; i < 400; i++)
                    send(2'($urandom_range(0, 3)), rand_imm(), $urandom);
                rand_phase = 1'b0;
            end
            while (rand_phase) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        drain();
        check("err_count_rand", {16'd0, err_count}, 32'(model_cnt));

        out_ready = 1'b0;
        send(2'b00, 32'd1, 32'h13);
        check("bp_in_ready_after_1", {31'd0, in_ready}, 32'd1);
        send(2'b01, 32'd2, 32'h23);
        check("bp_in_ready_after_2", {31'd0, in_ready}, 32'd0);
        fork
            send(2'b11, 32'd16, 32'h6F);
            begin
                repeat (3) begin
                    @(posedge clk); #1;
                    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                    check("bp_hold_instr", out_instr, q[0][31:0]);
                    check("bp_stalled", {31'd0, in_ready}, 32'd0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 65537; i++)
            send(2'($urandom_range(0, 1)), 32'h800 + 32'($urandom_range(0, 100)), $urandom);
        check("err_count_sat", {16'd0, err_count}, 32'hFFFF);
        drain();
        check("err_count_sat_hold", {16'd0, err_count}, 32'hFFFF);

        out_ready = 1'b0;
        send(2'b00, 32'd5, 32'h13);
        send(2'b00, 32'd6, 32'h13);
        check("full_before_reset", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_err_count", {16'd0, err_count}, 32'd0);
        q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(2'b11, 32'hFFFFF000, 32'h6F);
        drain();
        check("final_err_count", {16'd0, err_count}, 32'(model_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Streaming immediate packer; inverse of the core's immediate extender.
- Takes a 32-bit instruction template, a signed immediate and an immediate format (I/S/B/J), and emits the 32-bit instruction word with the immediate scattered into the RISC-V bit positions.
- Sits in the test-program generator / boot-ROM builder path, ahead of instruction memory.
- Valid/ready on both sides; registered output with a one-entry skid buffer.

Parameters:
W, 32, immediate/instruction width; only 32 supported
CNT_W, 16, width of saturating range-error counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept an input word
imm_src  input  2  format: 00 I, 01 S, 10 B, 11 J
imm  input  W  signed immediate (byte offset for B/J)
base  input  32  template; immediate bit positions are ignored
out_valid  output  1  out_instr valid
out_ready  input  1  downstream accepts out_instr
out_instr  output  32  packed instruction
out_range_err  output  1  immediate of this word was not representable
err_count  output  CNT_W  saturating count of accepted range errors

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_instr=0, out_range_err=0, err_count=0, skid empty, in_ready=1.
- Packing (combinational, ahead of the register):
  - I: instr[31:20]=imm[11:0]; bits 19:0 taken from base.
  - S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0]; rest from base.
  - B: instr[31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; rest from base.
  - J: instr[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; rest from base.
- Range check: error set when the immediate is not representable.
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - On error the truncated bits are still packed; out_range_err travels with that word.
- Handshake:
  - Input accepted when in_valid && in_ready. Output transfers when out_valid && out_ready.
  - in_ready is registered and equals !skid_valid.
- Buffer states:
  - EMPTY: accept -> main register loaded, out_valid=1 next cycle (latency 1). Go to ONE.
  - ONE, no accept: pop -> EMPTY; no pop -> stay.
  - ONE, accept: pop -> main reloaded, stay ONE. No pop -> word goes to skid, go to FULL (in_ready=0 next cycle).
  - FULL: no accepts. Pop -> skid moves to main, go to ONE, in_ready=1 next cycle. No pop -> all outputs hold stable.
- Ordering is strict FIFO. No word is dropped or duplicated.
- err_count: increments by 1 on each accepted word with a range error. Saturates at all-ones with no wrap.
- Reset mid-stream: buffered words are discarded; state returns to EMPTY immediately.
- out_instr and out_range_err hold their value while out_valid=1 and out_ready=0.

Optional Feature:
- Macro IMM_ROUNDTRIP_CHECK_EN.
- Defined:
  - Adds output chk_err (1 bit, reset 0).
  - Each word loaded into the main register is decoded back: same field extraction plus sign extension per imm_src.
  - If range_err=0 and the decoded value differs from imm, chk_err is set sticky until reset.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- I: base=0x00000093, imm=0xFFFFFFFF, src=00, out_ready=1 -> next cycle out_instr=0xFFF00093, range_err=0.
- S and B:
  - base=0x00002023, imm=8, src=01 -> 0x00002423.
  - base=0x00000063, imm=0xFFFFFFFC, src=10 -> 0xFE000EE3.
- J and range error:
  - base=0x0000006F, imm=8, src=11 -> 0x0080006F.
  - I imm=2048, base=0x00000093 -> 0x80000093, range_err=1, err_count=1.
  - B imm=3 -> range_err=1, err_count=2.
- Backpressure: out_ready=0, three back-to-back inputs.
  - First two are accepted; in_ready=0 from the cycle after the second.
  - Release out_ready -> words appear in order, third is accepted after the first pop, no loss.
- Saturation and reset:
  - Force 0xFFFF+2 errors -> err_count stays 0xFFFF.
  - Assert rst_n=0 with FULL state -> out_valid=0 and in_ready=1 immediately, err_count=0.
